vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Sequences the single-port frame-buffer RAM between two requesters.
- Scanout reads come from the VGA timing chain (visible-area enables plus pixel address) and have absolute priority.
- Host pixel writes use a req/ack handshake and take the remaining cycles.
- The RAM is split into two banks for double buffering; a bank swap requested by the host is deferred to the frame boundary pulse so the picture never tears.

Parameters:
- ADDR_BIT, 19, pixel address width within one bank (640x480 = 307200 words).
- DATA_BIT, 8, pixel word width.
- WAIT_BIT, 10, width of the saturating host wait counter.
- MAX_WAIT, 800, wait cycles at or above which o_wr_starve asserts (about one line time).

Ports:
- clk  in  1  pixel clock; every output is updated on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_sclr  in  1  synchronous clear; same effect as reset.
- i_vis  in  1  scanout read request this cycle (horizontal address enable AND vertical address enable).
- i_rd_addr  in  ADDR_BIT  scanout pixel address within the bank.
- i_frame_en  in  1  one-cycle frame-boundary pulse from the vertical timing block; always falls in vertical blanking.
- i_wr_req  in  1  host write request; level signal.
- i_wr_addr  in  ADDR_BIT  host write address; held stable while i_wr_req=1.
- i_wr_data  in  DATA_BIT  host write data; held stable while i_wr_req=1.
- o_wr_ack  out  1  one-cycle pulse: the host write has been issued.
- i_swap_req  in  1  one-cycle pulse: swap display and draw banks at the next frame boundary.
- o_swap_pend  out  1  a swap is latched and waiting for i_frame_en.
- o_swap_ack  out  1  one-cycle pulse in the cycle the banks toggle.
- o_mem_en  out  1  RAM access strobe.
- o_mem_we  out  1  1 = write, 0 = read.
- o_mem_addr  out  ADDR_BIT+1  RAM address: {bank, address}.
- o_mem_wdata  out  DATA_BIT  RAM write data.
- o_rd_bank  out  1  bank currently being displayed.
- o_wr_starve  out  1  host wait count >= MAX_WAIT.

Behaviour:
- Reset (i_rst_n=0, asynchronous) and i_sclr=1 (synchronous) both force:
  - all o_mem_* = 0, o_wr_ack = 0, o_swap_ack = 0, o_swap_pend = 0, o_wr_starve = 0;
  - o_rd_bank = 0, internal draw bank = 1;
  - write FSM to W_IDLE, wait counter to 0.
  - Reset mid-handshake discards the in-flight write and any pending swap.
- The draw (write) bank is always the inverse of o_rd_bank.
- Every memory command is registered: a decision in cycle t appears on o_mem_* in cycle t+1. One command per cycle.
- Scanout read: i_vis=1 in cycle t -> in t+1, o_mem_en=1, o_mem_we=0, o_mem_addr={o_rd_bank@t, i_rd_addr@t}. The bench sees read data at the RAM's own latency after that.
- Write FSM:
  - W_IDLE: if i_wr_req & ~i_vis -> grant. In t+1: o_mem_en=1, o_mem_we=1, o_mem_addr={draw bank@t, i_wr_addr}, o_mem_wdata=i_wr_data, o_wr_ack=1; go to W_ACK.
  - W_ACK: lasts one cycle, never grants (the host is still dropping i_wr_req); return to W_IDLE. Peak write rate is therefore 1 per 2 cycles.
- Priority: i_vis=1 together with a pending i_wr_req -> the read wins and the write waits. No preemption, no scanout underrun.
- When neither requester is granted: o_mem_en=0, o_mem_we=0; address and data hold their last value.
- Wait counter:
  - increments each cycle i_wr_req=1 and no grant is made; saturates at 2^WAIT_BIT-1;
  - clears in the grant cycle and whenever i_wr_req=0;
  - o_wr_starve is registered from (count >= MAX_WAIT).
- Swap FSM:
  - S_IDLE: i_swap_req -> S_PEND (o_swap_pend=1).
  - S_PEND: on i_frame_en, toggle o_rd_bank (and therefore the draw bank), pulse o_swap_ack for 1 cycle, return to S_IDLE.
  - Further i_swap_req pulses while in S_PEND are ignored.
  - i_swap_req and i_frame_en in the same cycle while in S_IDLE: latch only; the swap happens at the next frame.
- Simultaneous write grant and bank toggle in cycle t: the write uses the pre-toggle draw bank sampled at t.

Decomposition:
- Shared include vram_defs.v holds: ADDR_BIT/DATA_BIT defaults, write FSM encodings (W_IDLE, W_ACK), swap FSM encodings (S_IDLE, S_PEND).
- One sub-module: sat_counter_en, a saturating counter with enable and synchronous clear, used for the wait counter.

Test Plan:
- Reset then idle -> o_rd_bank=0, o_mem_en=0, o_swap_pend=0; the first write lands at address {1, addr}.
- i_wr_req with addr=0x00010, data=0xA5, i_vis=0 -> next cycle o_mem_we=1, o_mem_addr=0x80010, o_mem_wdata=0xA5, o_wr_ack=1; i_wr_req held 3 cycles produces exactly 1 ack.
- i_vis=1 for 640 cycles with i_wr_req held -> 640 reads addressed {0, i_rd_addr}, no writes; the write issues 1 cycle after i_vis falls; the wait count reaches 640; MAX_WAIT=600 -> o_wr_starve=1 before the grant, 0 after.
- i_swap_req pulse at a mid-frame line -> o_swap_pend=1 until i_frame_en; then o_swap_ack=1 for 1 cycle, o_rd_bank=1, and subsequent writes go to bank 0.
- i_swap_req and i_frame_en in the same cycle -> no toggle; the toggle occurs at the following i_frame_en.
- i_rst_n asserted low while in W_ACK with o_swap_pend=1 -> all outputs 0 immediately, without a clock edge; no swap at the next i_frame_en.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared widths and FSM encodings for the frame-buffer arbiter
package vram_arbiter_pkg;

  localparam int ADDR_BIT_DEF = 19;
  localparam int DATA_BIT_DEF = 8;
  localparam int WAIT_BIT_DEF = 10;
  localparam int MAX_WAIT_DEF = 800;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_ACK  = 1'b1
  } wr_state_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } swap_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - scanout, host write, bank swap and RAM command signals
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_BIT = ADDR_BIT_DEF,
  parameter int DATA_BIT = DATA_BIT_DEF
);

  logic                i_sclr;
  logic                i_vis;
  logic [ADDR_BIT-1:0] i_rd_addr;
  logic                i_frame_en;
  logic                i_wr_req;
  logic [ADDR_BIT-1:0] i_wr_addr;
  logic [DATA_BIT-1:0] i_wr_data;
  logic                o_wr_ack;
  logic                i_swap_req;
  logic                o_swap_pend;
  logic                o_swap_ack;
  logic                o_mem_en;
  logic                o_mem_we;
  logic [ADDR_BIT:0]   o_mem_addr;
  logic [DATA_BIT-1:0] o_mem_wdata;
  logic                o_rd_bank;
  logic                o_wr_starve;

  modport slave (
    input  i_sclr, i_vis, i_rd_addr, i_frame_en,
    input  i_wr_req, i_wr_addr, i_wr_data, i_swap_req,
    output o_wr_ack, o_swap_pend, o_swap_ack,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_rd_bank, o_wr_starve
  );

  modport master (
    output i_sclr, i_vis, i_rd_addr, i_frame_en,
    output i_wr_req, i_wr_addr, i_wr_data, i_swap_req,
    input  o_wr_ack, o_swap_pend, o_swap_ack,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_rd_bank, o_wr_starve
  );

endinterface

// File: rtl/vram_arbiter_sat_counter_en.sv
// rtl/vram_arbiter_sat_counter_en.sv - saturating up-counter with enable and synchronous clear
module sat_counter_en #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port frame-buffer sequencer: scanout reads first, host writes fill the gaps,
// double-buffer bank swap deferred to the frame boundary.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_BIT = ADDR_BIT_DEF,
  parameter int DATA_BIT = DATA_BIT_DEF,
  parameter int WAIT_BIT = WAIT_BIT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input logic          clk,
  input logic          i_rst_n,
  vram_arbiter_if.slave bus
);

  localparam logic [31:0] MAX_WAIT_U = MAX_WAIT;

  wr_state_t           wr_state, wr_next;
  swap_state_t         swap_state, swap_next;
  logic                grant_rd, grant_wr, swap_fire;
  logic                rd_bank;
  logic                wr_ack, swap_ack, starve;
  logic                mem_en, mem_we;
  logic [ADDR_BIT:0]   mem_addr;
  logic [DATA_BIT-1:0] mem_wdata;
  logic [WAIT_BIT-1:0] wait_cnt;
  logic                wait_clr, wait_en;

  // Scanout always wins; a write is only granted in W_IDLE on a non-visible cycle.
  always_comb begin
    grant_rd = bus.i_vis;
    grant_wr = 1'b0;
    wr_next  = wr_state;
    case (wr_state)
      W_IDLE: begin
        if (bus.i_wr_req && !bus.i_vis) begin
          grant_wr = 1'b1;
          wr_next  = W_ACK;
        end
      end
      W_ACK:   wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    swap_next = swap_state;
    swap_fire = 1'b0;
    case (swap_state)
      S_IDLE: if (bus.i_swap_req) swap_next = S_PEND;
      S_PEND: begin
        if (bus.i_frame_en) begin
          swap_fire = 1'b1;
          swap_next = S_IDLE;
        end
      end
      default: swap_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_state   <= W_IDLE;
      swap_state <= S_IDLE;
      rd_bank    <= 1'b0;
    end else if (bus.i_sclr) begin
      wr_state   <= W_IDLE;
      swap_state <= S_IDLE;
      rd_bank    <= 1'b0;
    end else begin
      wr_state   <= wr_next;
      swap_state <= swap_next;
      if (swap_fire) rd_bank <= ~rd_bank;
    end
  end

  // Draw bank is ~rd_bank as sampled this cycle, so a write granted alongside a toggle uses the old draw bank.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      swap_ack  <= 1'b0;
      starve    <= 1'b0;
    end else if (bus.i_sclr) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      swap_ack  <= 1'b0;
      starve    <= 1'b0;
    end else begin
      mem_en   <= grant_rd | grant_wr;
      mem_we   <= grant_wr;
      wr_ack   <= grant_wr;
      swap_ack <= swap_fire;
      starve   <= (32'(wait_cnt) >= MAX_WAIT_U);
      if (grant_rd) begin
        mem_addr <= {rd_bank, bus.i_rd_addr};
      end else if (grant_wr) begin
        mem_addr  <= {~rd_bank, bus.i_wr_addr};
        mem_wdata <= bus.i_wr_data;
      end
    end
  end

  assign wait_clr = bus.i_sclr | ~bus.i_wr_req | grant_wr;
  assign wait_en  = bus.i_wr_req;

  sat_counter_en #(
    .WIDTH (WAIT_BIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (i_rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .count (wait_cnt)
  );

  assign bus.o_mem_en    = mem_en;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_wr_ack    = wr_ack;
  assign bus.o_swap_ack  = swap_ack;
  assign bus.o_swap_pend = (swap_state == S_PEND);
  assign bus.o_rd_bank   = rd_bank;
  assign bus.o_wr_starve = starve;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed scoreboard bench for vram_arbiter
module tb_vram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  vram_arbiter_if #(.ADDR_BIT(19), .DATA_BIT(8)) bus ();

  vram_arbiter #(
    .ADDR_BIT (19),
    .DATA_BIT (8),
    .WAIT_BIT (10),
    .MAX_WAIT (600)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        en;
    logic        we;
    logic        ack;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic en, input logic we, input logic ack,
                      input logic [19:0] addr, input logic [7:0] wdata);
    exp_t e;
    e.en = en; e.we = we; e.ack = ack; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic push_idle();
    push(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
  endtask

  // Advance one cycle; outputs seen 1ns after the edge belong to the previous cycle's decision.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_en", 32'(bus.o_mem_en), 32'(e.en));
      chk("mem_we", 32'(bus.o_mem_we), 32'(e.we));
      chk("wr_ack", 32'(bus.o_wr_ack), 32'(e.ack));
      if (e.en) chk("mem_addr", 32'(bus.o_mem_addr), 32'(e.addr));
      if (e.we) chk("mem_wdata", 32'(bus.o_mem_wdata), 32'(e.wdata));
    end
  endtask

  initial begin
    bus.i_sclr     = 1'b0;
    bus.i_vis      = 1'b0;
    bus.i_rd_addr  = '0;
    bus.i_frame_en = 1'b0;
    bus.i_wr_req   = 1'b0;
    bus.i_wr_addr  = '0;
    bus.i_wr_data  = '0;
    bus.i_swap_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_bank", 32'(bus.o_rd_bank), 32'd0);
    chk("rst_mem_en", 32'(bus.o_mem_en), 32'd0);
    chk("rst_swap_pend", 32'(bus.o_swap_pend), 32'd0);
    chk("rst_starve", 32'(bus.o_wr_starve), 32'd0);
    rst_n = 1'b1;

    push_idle(); tick();
    push_idle(); tick();

    // First write after reset goes to draw bank 1; host drops req once it sees ack.
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 19'h00010; bus.i_wr_data = 8'hA5;
    push(1'b1, 1'b1, 1'b1, 20'h80010, 8'hA5); tick();
    push_idle(); tick();
    bus.i_wr_req = 1'b0;
    push_idle(); tick();

    // Top-of-bank address, two writes spaced by the mandatory W_ACK cycle.
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 19'h7FFFF; bus.i_wr_data = 8'h3C;
    push(1'b1, 1'b1, 1'b1, 20'hFFFFF, 8'h3C); tick();
    push_idle(); tick();
    bus.i_wr_addr = 19'h00000; bus.i_wr_data = 8'hC3;
    push(1'b1, 1'b1, 1'b1, 20'h80000, 8'hC3); tick();
    bus.i_wr_req = 1'b0;
    push_idle(); tick();

    bus.i_vis = 1'b1; bus.i_rd_addr = 19'h00123;
    push(1'b1, 1'b0, 1'b0, 20'h00123, 8'h0); tick();
    bus.i_vis = 1'b0;
    push_idle(); tick();

    // A full visible line with a write pending: reads only, starvation flag trips at 600.
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 19'h00055; bus.i_wr_data = 8'h11;
    for (int k = 0; k < 640; k++) begin
      bus.i_vis = 1'b1; bus.i_rd_addr = 19'(k);
      push(1'b1, 1'b0, 1'b0, {1'b0, 19'(k)}, 8'h0);
      tick();
      if (k == 300 || k == 599) chk("starve_low", 32'(bus.o_wr_starve), 32'd0);
      if (k == 600) chk("starve_high", 32'(bus.o_wr_starve), 32'd1);
    end
    bus.i_vis = 1'b0;
    push(1'b1, 1'b1, 1'b1, 20'h80055, 8'h11); tick();
    chk("starve_at_grant", 32'(bus.o_wr_starve), 32'd1);
    bus.i_wr_req = 1'b0;
    push_idle(); tick();
    chk("starve_cleared", 32'(bus.o_wr_starve), 32'd0);

    // Mid-frame swap request, committed at the frame pulse alongside a write to the old draw bank.
    bus.i_swap_req = 1'b1;
    push_idle(); tick();
    bus.i_swap_req = 1'b0;
    chk("swap_pend_set", 32'(bus.o_swap_pend), 32'd1);
    push_idle(); tick();
    chk("swap_pend_hold", 32'(bus.o_swap_pend), 32'd1);
    chk("rd_bank_pre", 32'(bus.o_rd_bank), 32'd0);
    bus.i_frame_en = 1'b1;
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 19'h00022; bus.i_wr_data = 8'h77;
    push(1'b1, 1'b1, 1'b1, 20'h80022, 8'h77); tick();
    bus.i_frame_en = 1'b0;
    chk("swap_ack", 32'(bus.o_swap_ack), 32'd1);
    chk("rd_bank_post", 32'(bus.o_rd_bank), 32'd1);
    chk("swap_pend_clr", 32'(bus.o_swap_pend), 32'd0);
    push_idle(); tick();
    chk("swap_ack_pulse", 32'(bus.o_swap_ack), 32'd0);
    bus.i_wr_req = 1'b0;
    push_idle(); tick();
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 19'h00033; bus.i_wr_data = 8'h5A;
    push(1'b1, 1'b1, 1'b1, 20'h00033, 8'h5A); tick();
    bus.i_wr_req = 1'b0;
    push_idle(); tick();
    bus.i_vis = 1'b1; bus.i_rd_addr = 19'h00005;
    push(1'b1, 1'b0, 1'b0, 20'h80005, 8'h0); tick();
    bus.i_vis = 1'b0;

    // Request coinciding with a frame pulse only latches; toggle waits for the next pulse.
    bus.i_swap_req = 1'b1; bus.i_frame_en = 1'b1;
    push_idle(); tick();
    bus.i_swap_req = 1'b0; bus.i_frame_en = 1'b0;
    chk("same_cyc_pend", 32'(bus.o_swap_pend), 32'd1);
    chk("same_cyc_ack", 32'(bus.o_swap_ack), 32'd0);
    chk("same_cyc_bank", 32'(bus.o_rd_bank), 32'd1);
    push_idle(); tick();
    bus.i_frame_en = 1'b1;
    push_idle(); tick();
    bus.i_frame_en = 1'b0;
    chk("next_frame_ack", 32'(bus.o_swap_ack), 32'd1);
    chk("next_frame_bank", 32'(bus.o_rd_bank), 32'd0);

    // Asynchronous reset while in W_ACK with a swap pending.
    bus.i_swap_req = 1'b1;
    push_idle(); tick();
    bus.i_swap_req = 1'b0;
    bus.i_wr_req = 1'b1; bus.i_wr_addr = 19'h00044; bus.i_wr_data = 8'h99;
    push(1'b1, 1'b1, 1'b1, 20'h80044, 8'h99); tick();
    chk("pre_rst_pend", 32'(bus.o_swap_pend), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_mem_en", 32'(bus.o_mem_en), 32'd0);
    chk("arst_mem_we", 32'(bus.o_mem_we), 32'd0);
    chk("arst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
    chk("arst_mem_wdata", 32'(bus.o_mem_wdata), 32'd0);
    chk("arst_wr_ack", 32'(bus.o_wr_ack), 32'd0);
    chk("arst_swap_pend", 32'(bus.o_swap_pend), 32'd0);
    chk("arst_rd_bank", 32'(bus.o_rd_bank), 32'd0);
    exp_q.delete();
    bus.i_wr_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_frame_en = 1'b1;
    push_idle(); tick();
    bus.i_frame_en = 1'b0;
    chk("post_rst_no_swap", 32'(bus.o_swap_ack), 32'd0);
    chk("post_rst_bank", 32'(bus.o_rd_bank), 32'd0);

    // Synchronous clear drops a pending swap.
    bus.i_swap_req = 1'b1;
    push_idle(); tick();
    bus.i_swap_req = 1'b0;
    chk("sclr_pre_pend", 32'(bus.o_swap_pend), 32'd1);
    bus.i_sclr = 1'b1;
    push_idle(); tick();
    bus.i_sclr = 1'b0;
    chk("sclr_pend", 32'(bus.o_swap_pend), 32'd0);
    bus.i_frame_en = 1'b1;
    push_idle(); tick();
    bus.i_frame_en = 1'b0;
    chk("sclr_no_swap", 32'(bus.o_swap_ack), 32'd0);
    chk("sclr_bank", 32'(bus.o_rd_bank), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
